// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator behind a two-entry skid buffer.
// The immediate, error flag and tag are computed when a beat is accepted.
// The buffer then holds them until downstream takes them. in_ready and
// out_valid are registered, so no combinational path runs from out_ready
// back to in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immType,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immOut,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t state_q;
  state_t state_d;
  entry_t main_q;
  entry_t skid_q;
  entry_t beat;
  logic   [31:0] imm32;
  logic          imm_err;
  logic          accept;
  logic          deq;

  assign accept = in_valid && in_ready;
  assign deq    = out_valid && out_ready;

  // Decode the immediate at 32 bits. Every format's bit 31 is instr[31]
  // (or 0 for SHAMT), so widening to XLEN is a plain sign extension.
  always_comb begin
    // NOTE: every comb output gets a default first so that no path infers a latch.
    imm32   = '0;
    imm_err = 1'b0;
    case (immType)
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b010:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b011:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      3'b101:  imm32 = {instr[31:12], 12'b0};
      3'b110:  imm32 = (XLEN == 64) ? {26'b0, instr[25:20]}
                                    : {27'b0, instr[24:20]};
      default: imm_err = 1'b1;
    endcase
    beat.imm = XLEN'($signed(imm32));
    beat.err = imm_err;
    beat.tag = in_tag;
  end

  // Next buffer state from the accept and output-transfer events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !deq)      state_d = TWO;
        else if (!accept && deq) state_d = EMPTY;
      end
      TWO:     if (deq) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Buffer registers: reset dominates flush, and flush dominates traffic.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      // NOTE: only main is cleared because it drives immOut and out_tag.
      // skid is always written before it is read, so it needs no reset.
      state_q   <= EMPTY;
      main_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side below sees the values from before this edge.
      state_q   <= state_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != TWO);
      case (state_q)
        EMPTY: if (accept) main_q <= beat;
        ONE: begin
          if (accept && !deq)     skid_q <= beat;
          else if (accept && deq) main_q <= beat;
        end
        TWO:   if (deq) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign immOut  = main_q.imm;
  assign out_err = main_q.err;
  assign out_tag = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with the same
// beats. A queue model of the two-entry buffer and a format table predict
// every output cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  immType;
  logic [31:0] instr, in_tag;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32, tag32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .immType(immType), .instr(instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .immOut(imm32),
    .out_tag(tag32), .out_err(err32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .immType(immType), .instr(instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .immOut(imm64),
    .out_tag(tag64), .out_err(err64));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Format table, written directly from the format definitions at 64 bits.
  function automatic logic [63:0] ref_imm(input logic [2:0] t, input logic [31:0] i,
                                          input bit x64);
    logic [63:0] v;
    case (t)
      3'd1: v = {{52{i[31]}}, i[31:20]};
      3'd2: v = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd3: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: v = {{32{i[31]}}, i[31:12], 12'b0};
      3'd6: v = x64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
      default: v = '0;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic        err;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  bit   m_in_ready = 1'b1;

  // Reference: a FIFO of depth two that accepts only while it is not full.
  always @(posedge clk) begin
    bit   deq, acc;
    exp_t e;
    if (!rst_n || flush) begin
      q.delete();
      m_in_ready = 1'b1;
    end else begin
      deq = (q.size() > 0) && out_ready;
      acc = in_valid && m_in_ready;
      if (deq) void'(q.pop_front());
      if (acc) begin
        e.i32 = ref_imm(immType, instr, 1'b0) & 64'hFFFF_FFFF;
        e.i64 = ref_imm(immType, instr, 1'b1);
        e.err = (immType == 3'd0) || (immType == 3'd7);
        e.tag = in_tag;
        q.push_back(e);
      end
      m_in_ready = (q.size() < 2);
    end
  end

  // Check both instances against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid32", out_valid32, q.size() > 0);
      check("valid64", out_valid64, q.size() > 0);
      check("in_ready32", in_ready32, m_in_ready);
      check("in_ready64", in_ready64, m_in_ready);
      if (q.size() > 0) begin
        check("imm32", imm32, q[0].i32);
        check("imm64", imm64, q[0].i64);
        check("tag32", tag32, q[0].tag);
        check("tag64", tag64, q[0].tag);
        check("err32", err32, q[0].err);
        check("err64", err64, q[0].err);
      end
    end
  end

  // Presents one beat and holds it until it is accepted, within a bounded number of cycles.
  // It is called and returns at posedge+1.
  task automatic send(input logic [2:0] t, input logic [31:0] i, input logic [31:0] tg);
    int n = 0;
    bit took;
    immType = t; instr = i; in_tag = tg; in_valid = 1'b1;
    do begin
      @(negedge clk); took = in_ready32;
      @(posedge clk); #1; n++;
    end while (!took && n < 50);
    check("send_accept", took, 1'b1);
    in_valid = 1'b0;
    instr = 'x;
  endtask

  task automatic beat(input logic [2:0] t, input logic [31:0] i, input logic [31:0] tg);
    immType = t; instr = i; in_tag = tg; in_valid = 1'b1;
  endtask

  initial begin
    int  n;
    bit  took;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    immType = '0; instr = '0; in_tag = '0;

    // Spot-check the format table against hand-decoded values.
    check("pin_I",  ref_imm(3'd1, 32'hFFF00093, 1'b0) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    check("pin_B",  ref_imm(3'd3, 32'hFE000EE3, 1'b0) & 64'hFFFF_FFFF, 64'hFFFF_FFFC);
    check("pin_U",  ref_imm(3'd5, 32'h123450B7, 1'b0) & 64'hFFFF_FFFF, 64'h1234_5000);
    check("pin_J",  ref_imm(3'd4, 32'h800000EF, 1'b1), 64'hFFFF_FFFF_FFF0_0000);
    check("pin_SH", ref_imm(3'd6, 32'h03F01013, 1'b1), 64'h3F);

    // Reset state.
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid32, 1'b0);
    check("rst_imm",   imm32, 32'h0);
    check("rst_tag",   tag32, 32'h0);
    check("rst_err",   err32, 1'b0);
    check("rst_ready", in_ready32, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // I-type beat with a one-cycle latency.
    out_ready = 1'b1;
    beat(3'd1, 32'hFFF00093, 32'h10);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("i_valid", out_valid32, 1'b1);
    check("i_imm",   imm32, 32'hFFFF_FFFF);
    check("i_tag",   tag32, 32'h10);
    check("i_err",   err32, 1'b0);
    @(posedge clk); #1;

    // B-type and U-type beats back to back.
    beat(3'd3, 32'hFE000EE3, 32'h21);
    @(posedge clk); #1 beat(3'd5, 32'h123450B7, 32'h22);
    @(negedge clk); check("b_imm", imm32, 32'hFFFF_FFFC);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("u_valid", out_valid32, 1'b1);
    check("u_imm",   imm32, 32'h1234_5000);
    @(posedge clk); #1;

    // Backpressure: A and B fill the buffer and C waits.
    out_ready = 1'b0;
    send(3'd1, 32'h00500093, 32'hA);
    send(3'd2, 32'h00112623, 32'hB);
    beat(3'd1, 32'h7FF00093, 32'hC);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", in_ready32, 1'b0);
      check("bp_hold",  tag32, 32'hA);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk); took = in_ready32;
      @(posedge clk); #1; n++;
    end while (!took && n < 10);
    check("bp_c_accept", took, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // An illegal format yields zero with the error flag set.
    beat(3'd7, 32'hDEADBEEF, 32'h77);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("ill_err", err32, 1'b1);
    check("ill_imm", imm32, 32'h0);
    @(posedge clk); #1;

    // Flush with two entries buffered and a beat presented in the flush cycle.
    out_ready = 1'b0;
    send(3'd1, 32'h00100093, 32'h31);
    send(3'd1, 32'h00200093, 32'h32);
    beat(3'd1, 32'h00300093, 32'h33);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_valid", out_valid32, 1'b0);
    check("fl_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // XLEN=64: J-type and SHAMT beats.
    beat(3'd4, 32'h800000EF, 32'h41);
    @(posedge clk); #1 beat(3'd6, 32'h03F01013, 32'h42);
    @(negedge clk); check("j64_imm", imm64, 64'hFFFF_FFFF_FFF0_0000);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("sh64_imm", imm64, 64'h3F);
    check("sh32_imm", imm32, 32'h1F);
    @(posedge clk); #1;

    // Reset mid-stream with two entries buffered.
    out_ready = 1'b0;
    send(3'd2, 32'hFE112E23, 32'h51);
    send(3'd5, 32'hFFFFF0B7, 32'h52);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mr_valid", out_valid32, 1'b0);
    check("mr_imm",   imm32, 32'h0);
    check("mr_ready", in_ready32, 1'b1);
    @(posedge clk); #1;

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(99) != 0);
      flush     = ($urandom_range(49) == 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      immType   = 3'($urandom_range(7));
      instr     = in_valid ? $urandom() : 'x;
      in_tag    = $urandom();
      @(posedge clk); #1;
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the immediate output width; legal values are 32 and 64.
REQ-002 Parameter TAG_W, default 32, sets the width of the sideband tag carried with each immediate (PC or instruction ID).
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: synchronous and active-low.
REQ-005 Port flush, input, 1, synchronously discards all buffered entries.
REQ-006 Port in_valid, input, 1, marks the input beat valid.
REQ-007 Port in_ready, output, 1, means the block can accept a beat.
REQ-008 Port immType, input, 3, selects the immediate format.
REQ-009 Port instr, input, 32, carries the raw instruction word.
REQ-010 Port in_tag, input, TAG_W, is the sideband tag.
REQ-011 Port out_valid, output, 1, marks the output beat valid.
REQ-012 Port out_ready, input, 1, is downstream acceptance.
REQ-013 Port immOut, output, XLEN, is the generated immediate.
REQ-014 Port out_tag, output, TAG_W, is the tag of the output beat.
REQ-015 Port out_err, output, 1, flags an illegal immType on the output beat.

Function
REQ-016 Format encoding (s = instr[31] replicated to XLEN):
- 001 I: s, instr[31:20]
- 010 S: s, instr[31:25], instr[11:7]
- 011 B: s, instr[31], instr[7], instr[30:25], instr[11:8], 0
- 100 J: s, instr[31], instr[19:12], instr[20], instr[30:21], 0
- 101 U: s, instr[31:12], 12'b0
- 110 SHAMT: zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64
REQ-017 immType 000 and 111 are illegal: immOut = 0 and out_err = 1 for that beat; out_err = 0 for every other code.
REQ-018 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-019 Storage is two entries, main and skid, each holding immOut, out_err and out_tag, computed at accept time.
REQ-020 Latency: a beat accepted in cycle N is presented on the outputs in cycle N+1 at the earliest.
REQ-021 Throughput: one beat per cycle while out_ready is held high.
REQ-022 Ordering: beats leave in acceptance order; none are dropped or duplicated except by flush or reset.
REQ-023 in_ready is a registered signal and equals !skid_full; it does not depend combinationally on out_ready.
REQ-024 Buffer states:
- EMPTY: out_valid = 0.
- ONE: main is valid.
- TWO: main and skid are valid, and in_ready = 0.
REQ-025 State transitions:
- EMPTY to ONE on accept.
- ONE to TWO on accept without output transfer.
- ONE to EMPTY on output transfer without accept.
- ONE stays ONE on simultaneous accept and output transfer; main takes the new beat.
- TWO to ONE on output transfer; skid moves to main.
REQ-026 Outputs stay stable (immOut, out_tag, out_err) while out_valid && !out_ready.
REQ-027 Flush has priority over every other event: next state is EMPTY, a beat presented in the flush cycle is discarded, and in_ready = 1 the following cycle.
REQ-028 Input fields are ignored while in_valid = 0; X on instr does not propagate when the input is not accepted.

Reset
REQ-029 On a clk edge with rst_n = 0:
- state goes to EMPTY;
- out_valid, out_err and immOut go to 0;
- out_tag goes to 0;
- in_ready goes to 1.
REQ-030 Reset asserted mid-operation discards all buffered beats, exactly as flush does, and reset dominates flush.

Verification
REQ-031 I-type: XLEN=32, immType=001, instr=0xFFF00093, tag=0x10, out_ready=1 -> next cycle out_valid=1, immOut=0xFFFFFFFF, out_tag=0x10, out_err=0.
REQ-032 B-type and U-type back-to-back:
- beat 1: 011 with 0xFE000EE3 -> immOut 0xFFFFFFFC;
- beat 2: 101 with 0x123450B7 -> immOut 0x12345000;
- outputs arrive on consecutive cycles.
REQ-033 Backpressure: out_ready=0, push beats A, B, C -> A and B are accepted, in_ready=0 from the cycle after B, C is held; raising out_ready outputs A, B, C in order with no gaps after C is accepted.
REQ-034 Illegal and flush:
- immType=111 beat -> immOut=0, out_err=1;
- with two entries buffered, pulse flush while in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle beat never appears.
REQ-035 XLEN=64 cases:
- J-type, immType=100, instr=0x800000EF -> immOut=0xFFFFFFFFFFF00000.
- SHAMT, immType=110, instr=0x03F01013 -> immOut=0x000000000000003F.
REQ-036 Reset mid-stream: rst_n=0 for one cycle with two entries buffered -> out_valid=0, immOut=0, in_ready=1 next cycle, and prior beats never emerge.
